// File: rtl/fifo_chk_pkg.sv
// fifo_chk_pkg: shared types for the FIFO read-side checker.
// Holds the FSM state encoding and counter widths.
package fifo_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  localparam int unsigned ERR_CNT_W  = 16;
  localparam int unsigned BEAT_CNT_W = 32;

endpackage

// File: rtl/fifo_chk_exp_gen.sv
// fifo_chk_exp_gen: expected packed counter word generator.
// Ports: clk_i/rst_i, adv_i (valid beat), lane_i (oldest lane of the
// beat, used for lock-on-first), exp_o (expected word), lock_o (the
// current beat is the lock beat and must not be checked).
module fifo_chk_exp_gen
  import fifo_chk_pkg::*;
#(
  parameter int unsigned          WR_WIDTH      = 16,
  parameter int unsigned          RATIO         = 2,
  parameter logic [WR_WIDTH-1:0]  SEED          = WR_WIDTH'(1),
  parameter bit                   LOCK_ON_FIRST = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        adv_i,
  input  logic [WR_WIDTH-1:0]         lane_i,
  output logic [WR_WIDTH*RATIO-1:0]   exp_o,
  output logic                        lock_o
);

  localparam int unsigned RD_W = WR_WIDTH * RATIO;
  localparam logic [WR_WIDTH-1:0] STEP = WR_WIDTH'(RATIO);

  logic [WR_WIDTH-1:0] e_q, e_d;
  logic                arm_q, arm_d;

  // Oldest sample sits in the MS lane.
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    assign exp_o[RD_W-1-g*WR_WIDTH -: WR_WIDTH] = e_q + WR_WIDTH'(g);
  end

  assign lock_o = arm_q;

  always_comb begin
    e_d   = e_q;
    arm_d = arm_q;
    if (adv_i) begin
      arm_d = 1'b0;
      e_d   = (arm_q ? lane_i : e_q) + STEP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q   <= SEED;
      arm_q <= LOCK_ON_FIRST;
    end else begin
      e_q   <= e_d;
      arm_q <= arm_d;
    end
  end

endmodule

// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: drains a FIFO once prog-full and checks each wide
// beat against the packed incrementing counter sequence.
// Ports: rd_clk_i/rst_i; FIFO flags rst_busy_i, prog_full_i, empty_i;
// run_i gate; rd_en_o; rdata_i/rd_valid_i; error_o, err_cnt_o,
// beat_cnt_o, first_err_data_o, first_err_exp_o, state_o.
module fifo_rd_checker
  import fifo_chk_pkg::*;
#(
  parameter int unsigned          WR_WIDTH      = 16,
  parameter int unsigned          RD_WIDTH      = 32,
  parameter logic [WR_WIDTH-1:0]  SEED          = WR_WIDTH'(1),
  parameter bit                   LOCK_ON_FIRST = 1'b0
) (
  input  logic                  rd_clk_i,
  input  logic                  rst_i,
  input  logic                  rst_busy_i,
  input  logic                  prog_full_i,
  input  logic                  empty_i,
  input  logic                  run_i,
  output logic                  rd_en_o,
  input  logic [RD_WIDTH-1:0]   rdata_i,
  input  logic                  rd_valid_i,
  output logic                  error_o,
  output logic [15:0]           err_cnt_o,
  output logic [31:0]           beat_cnt_o,
  output logic [RD_WIDTH-1:0]   first_err_data_o,
  output logic [RD_WIDTH-1:0]   first_err_exp_o,
  output logic [1:0]            state_o
);

  localparam int unsigned RATIO = RD_WIDTH / WR_WIDTH;

  state_e                state_q;
  logic [RD_WIDTH-1:0]   exp_w;
  logic                  lock_w;
  logic                  mis_w;

  logic                  error_q, error_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic [RD_WIDTH-1:0]   fd_q, fd_d;
  logic [RD_WIDTH-1:0]   fe_q, fe_d;

  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (!rst_busy_i) state_q <= ST_FILL;
        ST_FILL: begin
          if (rst_busy_i)       state_q <= ST_IDLE;
          else if (prog_full_i) state_q <= ST_STREAM;
        end
        ST_STREAM: if (rst_busy_i) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Combinational so an empty FIFO is never read.
  assign rd_en_o = (state_q == ST_STREAM) & ~empty_i & run_i;
  assign state_o = state_q;

  fifo_chk_exp_gen #(
    .WR_WIDTH      (WR_WIDTH),
    .RATIO         (RATIO),
    .SEED          (SEED),
    .LOCK_ON_FIRST (LOCK_ON_FIRST)
  ) u_exp (
    .clk_i  (rd_clk_i),
    .rst_i  (rst_i),
    .adv_i  (rd_valid_i),
    .lane_i (rdata_i[RD_WIDTH-1 -: WR_WIDTH]),
    .exp_o  (exp_w),
    .lock_o (lock_w)
  );

  assign mis_w = rd_valid_i & ~lock_w & (rdata_i != exp_w);

  always_comb begin
    error_d = error_q;
    err_d   = err_q;
    beat_d  = beat_q;
    fd_d    = fd_q;
    fe_d    = fe_q;
    if (rd_valid_i) begin
      beat_d = beat_q + BEAT_CNT_W'(1);
    end
    if (mis_w) begin
      error_d = 1'b1;
      if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
      if (!error_q) begin
        fd_d = rdata_i;
        fe_d = exp_w;
      end
    end
  end

  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      error_q <= 1'b0;
      err_q   <= '0;
      beat_q  <= '0;
      fd_q    <= '0;
      fe_q    <= '0;
    end else begin
      error_q <= error_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      fd_q    <= fd_d;
      fe_q    <= fe_d;
    end
  end

  assign error_o          = error_q;
  assign err_cnt_o        = err_q;
  assign beat_cnt_o       = beat_q;
  assign first_err_data_o = fd_q;
  assign first_err_exp_o  = fe_q;

endmodule

// File: tb/tb_fifo_rd_checker.sv
// tb_fifo_rd_checker: FIFO model + scoreboard bench for fifo_rd_checker.
// A second instance exercises lock-on-first and lane wrap.
module tb_fifo_rd_checker;
  import fifo_chk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, rst_busy_i, prog_full_i, empty_i, run_i;
  logic        rd_valid_i;
  logic [31:0] rdata_i;
  logic        rd_en_o, error_o;
  logic [15:0] err_cnt_o;
  logic [31:0] beat_cnt_o, fd_o, fe_o;
  logic [1:0]  state_o;

  logic        lk_rst, lk_valid;
  logic [31:0] lk_data;
  logic        lk_rd_en, lk_error;
  logic [15:0] lk_err;
  logic [31:0] lk_beat, lk_fd, lk_fe;
  logic [1:0]  lk_state;

  fifo_rd_checker dut (
    .rd_clk_i         (clk),
    .rst_i            (rst_i),
    .rst_busy_i       (rst_busy_i),
    .prog_full_i      (prog_full_i),
    .empty_i          (empty_i),
    .run_i            (run_i),
    .rd_en_o          (rd_en_o),
    .rdata_i          (rdata_i),
    .rd_valid_i       (rd_valid_i),
    .error_o          (error_o),
    .err_cnt_o        (err_cnt_o),
    .beat_cnt_o       (beat_cnt_o),
    .first_err_data_o (fd_o),
    .first_err_exp_o  (fe_o),
    .state_o          (state_o)
  );

  fifo_rd_checker #(.LOCK_ON_FIRST(1'b1)) dut_lk (
    .rd_clk_i         (clk),
    .rst_i            (lk_rst),
    .rst_busy_i       (rst_busy_i),
    .prog_full_i      (prog_full_i),
    .empty_i          (empty_i),
    .run_i            (run_i),
    .rd_en_o          (lk_rd_en),
    .rdata_i          (lk_data),
    .rd_valid_i       (lk_valid),
    .error_o          (lk_error),
    .err_cnt_o        (lk_err),
    .beat_cnt_o       (lk_beat),
    .first_err_data_o (lk_fd),
    .first_err_exp_o  (lk_fe),
    .state_o          (lk_state)
  );

  typedef struct {
    logic [31:0] beat;
    logic [15:0] err;
    logic        error;
    logic [31:0] fd;
    logic [31:0] fe;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] fifo_q[$];
  logic        p0v, p1v;
  logic [31:0] p0d, p1d;
  logic [15:0] g_lane;

  logic [15:0] m_e, m_err;
  logic [31:0] m_beat, m_fd, m_fe;
  logic        m_error;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_e = 16'd1; m_err = '0; m_beat = '0;
    m_fd = '0; m_fe = '0; m_error = 1'b0;
  endtask

  task automatic model_beat(input logic [31:0] w);
    logic [31:0] x;
    exp_t e;
    x = {m_e, m_e + 16'd1};
    m_e = m_e + 16'd2;
    m_beat = m_beat + 32'd1;
    if (w !== x) begin
      if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
      if (!m_error) begin m_fd = w; m_fe = x; end
      m_error = 1'b1;
    end
    e.beat = m_beat; e.err = m_err; e.error = m_error;
    e.fd = m_fd; e.fe = m_fe;
    sb_q.push_back(e);
  endtask

  task automatic push_words(input int n, input int bad_idx,
                            input logic [31:0] bad);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = {g_lane, g_lane + 16'd1};
      g_lane = g_lane + 16'd2;
      if (i == bad_idx) w = bad;
      fifo_q.push_back(w);
    end
    if (n > 0) empty_i = 1'b0;
  endtask

  // One clock: score the beat the DUT just consumed, then advance the
  // FIFO model (2-cycle read latency) and present the next beat.
  task automatic cycle();
    logic        ren, nv, was_empty;
    logic [31:0] nd;
    exp_t        e;
    #2;
    ren = rd_en_o;
    @(posedge clk);
    #1;
    if (!rst_i && rd_valid_i) begin
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("beat_cnt", beat_cnt_o, e.beat);
        chk("err_cnt", err_cnt_o, e.err);
        chk("error", error_o, e.error);
        chk("first_data", fd_o, e.fd);
        chk("first_exp", fe_o, e.fe);
      end
    end
    nv = 1'b0; nd = '0;
    if (ren) begin
      chk("pop_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) begin nv = 1'b1; nd = fifo_q.pop_front(); end
    end
    rd_valid_i = p1v; rdata_i = p1d;
    p1v = p0v; p1d = p0d; p0v = nv; p0d = nd;
    if (rst_i) begin
      fifo_q.delete(); sb_q.delete();
      p0v = 1'b0; p1v = 1'b0; rd_valid_i = 1'b0;
      m_reset();
    end
    was_empty = empty_i;
    empty_i = (fifo_q.size() == 0);
    if (rd_valid_i) model_beat(rdata_i);
    #1;
    if (empty_i && !was_empty) chk("rd_en_on_empty", rd_en_o, 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || p0v || p1v || rd_valid_i) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", fifo_q.size() == 0 && !p0v && !p1v && !rd_valid_i, 1);
  endtask

  task automatic lk_beat_t(input logic [31:0] w);
    lk_valid = 1'b1; lk_data = w;
    @(posedge clk); #1;
    lk_valid = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; rst_busy_i = 1'b1; prog_full_i = 1'b0;
    empty_i = 1'b1; run_i = 1'b1; rd_valid_i = 1'b0; rdata_i = '0;
    lk_rst = 1'b1; lk_valid = 1'b0; lk_data = '0;
    p0v = 1'b0; p1v = 1'b0; p0d = '0; p1d = '0; g_lane = 16'd1;
    m_reset();

    // Lock-on-first instance.
    @(posedge clk); #1;
    lk_rst = 1'b0;
    chk("lk_rst_beat", lk_beat, 0);
    lk_beat_t(32'h1234_1235);
    lk_beat_t(32'h1236_1237);
    lk_beat_t(32'h1238_1239);
    chk("lk_error", lk_error, 0);
    chk("lk_beat", lk_beat, 3);
    lk_rst = 1'b1; @(posedge clk); #1; lk_rst = 1'b0;
    chk("lk_rst_clear", lk_beat, 0);
    lk_beat_t(32'hFFFD_FFFE);
    lk_beat_t(32'hFFFF_0000);
    lk_beat_t(32'h0001_0002);
    chk("lk_wrap_error", lk_error, 0);
    lk_beat_t(32'h0003_0005);
    chk("lk_bad_error", lk_error, 1);
    chk("lk_bad_cnt", lk_err, 1);
    chk("lk_bad_data", lk_fd, 32'h0003_0005);
    chk("lk_bad_exp", lk_fe, 32'h0003_0004);

    // Reset state, then IDLE while rst_busy is high.
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_error", error_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    chk("rst_beat", beat_cnt_o, 0);
    chk("rst_fd", fd_o, 0);
    chk("rst_fe", fe_o, 0);
    rst_i = 1'b0;
    repeat (10) begin
      cycle();
      chk("busy_idle", state_o, ST_IDLE);
      chk("busy_rd_en", rd_en_o, 0);
    end
    rst_busy_i = 1'b0;
    cycle();
    chk("fill_state", state_o, ST_FILL);
    push_words(150, -1, '0);
    repeat (3) begin
      cycle();
      chk("fill_hold", state_o, ST_FILL);
      chk("fill_rd_en", rd_en_o, 0);
    end

    // Clean drain of 150 beats.
    prog_full_i = 1'b1;
    #1;
    chk("pf_rd_en_same", rd_en_o, 0);
    cycle();
    chk("stream_state", state_o, ST_STREAM);
    chk("stream_rd_en", rd_en_o, 1);
    drain(400);
    chk("clean_beats", beat_cnt_o, 150);
    chk("clean_error", error_o, 0);

    // run_i gap.
    push_words(40, -1, '0);
    repeat (10) cycle();
    run_i = 1'b0;
    repeat (20) begin
      cycle();
      chk("gap_rd_en", rd_en_o, 0);
      chk("gap_state", state_o, ST_STREAM);
    end
    run_i = 1'b1;
    drain(200);
    chk("gap_beats", beat_cnt_o, 190);
    chk("gap_error", error_o, 0);

    // rst_busy pulse: back to IDLE, expected value retained.
    rst_busy_i = 1'b1;
    cycle();
    chk("busy_back_idle", state_o, ST_IDLE);
    rst_busy_i = 1'b0;
    cycle();
    chk("busy_refill", state_o, ST_FILL);
    cycle();
    chk("busy_restream", state_o, ST_STREAM);
    push_words(10, -1, '0);
    drain(100);
    chk("busy_beats", beat_cnt_o, 200);
    chk("busy_error", error_o, 0);

    // Reset mid-stream with beats in flight.
    push_words(20, -1, '0);
    repeat (5) cycle();
    chk("pre_rst_valid", rd_valid_i, 1);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("mrst_state", state_o, ST_IDLE);
    chk("mrst_beat", beat_cnt_o, 0);
    chk("mrst_rd_en", rd_en_o, 0);
    g_lane = 16'd1;

    // Restart from SEED with beat 5 corrupted.
    push_words(10, 4, 32'h0009_000B);
    drain(100);
    chk("bad_error", error_o, 1);
    chk("bad_cnt", err_cnt_o, 1);
    chk("bad_data", fd_o, 32'h0009_000B);
    chk("bad_exp", fe_o, 32'h0009_000A);
    chk("bad_beats", beat_cnt_o, 10);

    // Error counter saturation.
    run_i = 1'b0;
    rd_valid_i = 1'b1; rdata_i = '0;
    repeat (70000) @(posedge clk);
    #1;
    rd_valid_i = 1'b0;
    chk("sat_cnt", err_cnt_o, 16'hFFFF);
    chk("sat_beats", beat_cnt_o, 70010);
    chk("sat_first_kept", fd_o, 32'h0009_000B);

    // Final reset and clean restart.
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("frst_err_cnt", err_cnt_o, 0);
    chk("frst_error", error_o, 0);
    chk("frst_fe", fe_o, 0);
    g_lane = 16'd1;
    run_i = 1'b1;
    push_words(20, -1, '0);
    drain(100);
    chk("restart_beats", beat_cnt_o, 20);
    chk("restart_error", error_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
